mac_drain: RTL and testbench

//  Result-side reader for a row of MAC accumulators in the TPU datapath. On start,

---
 rtl/mac_drain.sv | 155 +++++++++++++++
 tb/tb_mac_drain.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_drain.sv
`default_nettype none
// ============================================================================
// Module   : mac_drain
// Brief    : Freezes a MAC row for one cycle, snapshots and clears its sums,
//            then streams the snapshot out one sum per valid/ready beat.
//            Optional checksum beat enabled by MAC_DRAIN_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mac_drain #(
    parameter int NUM_MACS  = 4,
    parameter int SUM_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_MACS*SUM_WIDTH-1:0] sums,
    output logic                          mac_hold,
    output logic                          mac_clr,
    output logic [SUM_WIDTH-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          busy
);

`ifdef MAC_DRAIN_CHECKSUM_EN
    localparam int c_BEATS = NUM_MACS + 1;
`else
    localparam int c_BEATS = NUM_MACS;
`endif
    localparam int                 c_IDX_W    = $clog2(c_BEATS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_BEATS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_SEND    = 2'd2;

    logic [1:0]           r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [SUM_WIDTH-1:0] r_shadow [NUM_MACS];
    logic                 r_mac_hold;
    logic                 r_mac_clr;
    logic [SUM_WIDTH-1:0] r_out_data;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic                 r_busy;

    logic [c_IDX_W-1:0]   w_idx_next;
    logic [SUM_WIDTH-1:0] w_next_data;
    logic                 w_next_last;

    assign w_idx_next  = r_idx + 1'b1;
    assign w_next_last = (w_idx_next == c_LAST_IDX);

`ifdef MAC_DRAIN_CHECKSUM_EN
    logic [SUM_WIDTH-1:0] w_checksum;

    // Modular sum over the frozen snapshot, never the live accumulators.
    always_comb begin
        w_checksum = '0;
        for (int i = 0; i < NUM_MACS; i++) begin
            w_checksum = w_checksum + r_shadow[i];
        end
    end
`endif

    // Data for the beat following the current one.
    always_comb begin
        w_next_data = '0;
        for (int i = 0; i < NUM_MACS; i++) begin
            if (w_idx_next == c_IDX_W'(i)) begin
                w_next_data = r_shadow[i];
            end
        end
`ifdef MAC_DRAIN_CHECKSUM_EN
        if (w_idx_next == c_IDX_W'(NUM_MACS)) begin
            w_next_data = w_checksum;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_mac_hold  <= 1'b0;
            r_mac_clr   <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < NUM_MACS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_CAPTURE;
                        r_mac_hold <= 1'b1;
                        r_mac_clr  <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    for (int i = 0; i < NUM_MACS; i++) begin
                        r_shadow[i] <= sums[i*SUM_WIDTH +: SUM_WIDTH];
                    end
                    // First beat comes straight from the sums being captured.
                    r_idx       <= '0;
                    r_state     <= S_SEND;
                    r_mac_hold  <= 1'b0;
                    r_mac_clr   <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_out_data  <= sums[0 +: SUM_WIDTH];
                    r_out_last  <= 1'b0;
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state     <= S_IDLE;
                            r_idx       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_idx      <= w_idx_next;
                            r_out_data <= w_next_data;
                            r_out_last <= w_next_last;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_idx       <= '0;
                    r_mac_hold  <= 1'b0;
                    r_mac_clr   <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign mac_hold  = r_mac_hold;
    assign mac_clr   = r_mac_clr;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mac_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_drain
// Brief    : Directed self-checking bench for mac_drain (NUM_MACS=4, SUM_WIDTH=8);
//            expectations follow MAC_DRAIN_CHECKSUM_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_drain;

    localparam int NUM_MACS  = 4;
    localparam int SUM_WIDTH = 8;
`ifdef MAC_DRAIN_CHECKSUM_EN
    localparam int c_BEATS = NUM_MACS + 1;
`else
    localparam int c_BEATS = NUM_MACS;
`endif

    logic                          clk;
    logic                          rst_n;
    logic                          start;
    logic [NUM_MACS*SUM_WIDTH-1:0] sums;
    logic                          mac_hold;
    logic                          mac_clr;
    logic [SUM_WIDTH-1:0]          out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_last;
    logic                          busy;

    int n_checks = 0;
    int n_errors = 0;

    mac_drain #(
        .NUM_MACS  (NUM_MACS),
        .SUM_WIDTH (SUM_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sums      (sums),
        .mac_hold  (mac_hold),
        .mac_clr   (mac_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first beat cycle with out_ready=1; ends in the first IDLE cycle.
    task automatic drain(input string tag, input logic [31:0] s);
        logic [7:0] csum;
        logic [7:0] exp;
        csum = s[7:0] + s[15:8] + s[23:16] + s[31:24];
        for (int b = 0; b < c_BEATS; b++) begin
            exp = (b < NUM_MACS) ? s[b*8 +: 8] : csum;
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_data"},  32'(out_data),  32'(exp));
            check({tag, "_last"},  32'(out_last),  32'(b == c_BEATS - 1));
            check({tag, "_clr"},   32'(mac_clr),   32'd0);
            check({tag, "_hold"},  32'(mac_hold),  32'd0);
            tick();
        end
        check({tag, "_end_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_end_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        sums      = '0;
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_clr",   32'(mac_clr),   32'd0);
        check("rst_hold",  32'(mac_hold),  32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: basic drain, out_ready always high
        sums      = 32'h40302010;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("t1_clr",   32'(mac_clr),   32'd1);
        check("t1_hold",  32'(mac_hold),  32'd1);
        check("t1_busy",  32'(busy),      32'd1);
        check("t1_valid", 32'(out_valid), 32'd0);
        tick();
        drain("t1", 32'h40302010);

        // 2: backpressure on beat 1
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t2_b0", 32'(out_data), 32'h10);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t2_stall_data",  32'(out_data),  32'h20);
            check("t2_stall_valid", 32'(out_valid), 32'd1);
            check("t2_stall_last",  32'(out_last),  32'd0);
            tick();
        end
        check("t2_held_data", 32'(out_data), 32'h20);
        out_ready = 1'b1;
        tick();
        check("t2_b2", 32'(out_data), 32'h30);
        tick();
        check("t2_b3",      32'(out_data), 32'h40);
        check("t2_b3_last", 32'(out_last), 32'(c_BEATS == NUM_MACS));
        tick();
`ifdef MAC_DRAIN_CHECKSUM_EN
        check("t2_csum",      32'(out_data), 32'hA0);
        check("t2_csum_last", 32'(out_last), 32'd1);
        tick();
`endif
        check("t2_end_valid", 32'(out_valid), 32'd0);

        // 3: live sums change during SEND; snapshot must stream
        sums  = 32'h40302010;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        sums = 32'hFFFFFFFF;
        drain("t3", 32'h40302010);

        // 4: start held high for the whole drain
        sums  = 32'h04030201;
        start = 1'b1;
        tick();
        check("t4_clr1", 32'(mac_clr), 32'd1);
        tick();
        drain("t4a", 32'h04030201);
        check("t4_idle_clr", 32'(mac_clr), 32'd0);
        tick();
        start = 1'b0;
        check("t4_clr2",  32'(mac_clr),  32'd1);
        check("t4_hold2", 32'(mac_hold), 32'd1);
        tick();
        drain("t4b", 32'h04030201);

        // 5: async reset during beat 2
        sums  = 32'h40302010;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("t5_b2", 32'(out_data), 32'h30);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_data",  32'(out_data),  32'd0);
        check("t5_rst_busy",  32'(busy),      32'd0);
        check("t5_rst_last",  32'(out_last),  32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_post_valid", 32'(out_valid), 32'd0);
            check("t5_post_busy",  32'(busy),      32'd0);
        end

        // 6: checksum wrap-around (plain data beats without the checksum build)
        sums  = 32'h808001FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        drain("t6", 32'h808001FF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
